// File: rtl/digit_serial_adder.sv
// -----------------------------------------------------------------------------
// digit_serial_adder
//
// Adds two N-bit unsigned operands D bits per clock using one D-bit adder
// slice and a registered carry. Result is N+1 bits wide (Sum[N] = carry-out).
// Operands enter and the sum leaves through valid/ready handshakes; only one
// operation is in flight at a time.
//
// Parameters:
//   N  operand width (>= 1)
//   D  digit width per clock (>= 1, <= N, N % D == 0)
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   operands (and cin / sub) are valid
//   in_ready   block can accept operands (IDLE only)
//   A, B       N-bit operands
//   cin        carry-in, captured with the operands
//   sub        (only with DIGIT_SERIAL_ADDER_SUBTRACT_EN) 1 = compute A - B
//   out_valid  Sum is valid (DONE only)
//   out_ready  consumer accepts Sum
//   Sum        N+1-bit result
//
// Optional feature macro: DIGIT_SERIAL_ADDER_SUBTRACT_EN
//   When defined, adds the sub input. With sub=1 the B register captures ~B
//   and the initial carry is forced to 1, giving A + ~B + 1. Sum[N]=1 means
//   no borrow.
//
// States:
//   S_IDLE | waiting for operands, in_ready=1
//   S_RUN  | adding one digit per cycle, K = N/D cycles
//   S_DONE | out_valid=1, Sum held until out_ready
// -----------------------------------------------------------------------------
module digit_serial_adder #(
  parameter int N = 8,
  parameter int D = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         cin,
`ifdef DIGIT_SERIAL_ADDER_SUBTRACT_EN
  input  logic         sub,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:0]   Sum
);

  generate
    if ((N < 1) || (D < 1) || (D > N) || ((N % D) != 0)) begin : g_bad_params
      $error("digit_serial_adder: illegal parameters N=%0d D=%0d", N, D);
    end
  endgenerate

  localparam int K  = N / D;
  localparam int CW = $clog2(K + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic [N-1:0]    r_a;
  logic [N-1:0]    r_b;
  logic            r_carry;
  logic [CW-1:0]   r_cnt;
  logic [N:0]      r_sum;

  logic            w_accept;
  logic            w_last;
  logic [CW-1:0]   w_idx;
  logic [D-1:0]    w_a_dig;
  logic [D-1:0]    w_b_dig;
  logic [D:0]      w_dig_sum;
  logic [N-1:0]    w_b_load;
  logic            w_c_load;

  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_cnt == CW'(K - 1));

  // The counter reaches K after the last digit; keep the slice index inside
  // the operand range outside RUN so the selects never go out of bounds.
  assign w_idx    = (r_state == S_RUN) ? r_cnt : '0;

  assign w_a_dig   = r_a[w_idx*D +: D];
  assign w_b_dig   = r_b[w_idx*D +: D];
  assign w_dig_sum = {1'b0, w_a_dig} + {1'b0, w_b_dig} + {{D{1'b0}}, r_carry};

`ifdef DIGIT_SERIAL_ADDER_SUBTRACT_EN
  // Subtraction as A + ~B + 1: invert B on capture and force the first carry.
  assign w_b_load = sub ? ~B   : B;
  assign w_c_load = sub ? 1'b1 : cin;
`else
  assign w_b_load = B;
  assign w_c_load = cin;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept)  w_next = S_RUN;
      S_RUN:  if (w_last)    w_next = S_DONE;
      S_DONE: if (out_ready) w_next = S_IDLE;
      default:               w_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (r_state == S_IDLE) && !rst;
    out_valid = (r_state == S_DONE);
  end

  // Datapath: operand capture and one digit per RUN cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
    end else if (w_accept) begin
      r_a     <= A;
      r_b     <= w_b_load;
      r_carry <= w_c_load;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_sum[w_idx*D +: D] <= w_dig_sum[D-1:0];
      r_carry             <= w_dig_sum[D];
      r_cnt               <= r_cnt + CW'(1);
      if (w_last) begin
        r_sum[N] <= w_dig_sum[D];
      end
    end
  end

  assign Sum = r_sum;

endmodule

// File: tb/tb_digit_serial_adder.sv
// -----------------------------------------------------------------------------
// Testbench for digit_serial_adder. Instances: N=4/D=2 (main), N=8/D=8 and
// N=8/D=1 (wide/latency). Expected sums are pushed on send and popped when the
// DUT presents out_valid. Inputs change and outputs are sampled on negedge.
// -----------------------------------------------------------------------------
module tb_digit_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       iv4 = 1'b0, cin4 = 1'b0, or4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       ir4, ov4;
  logic [4:0] sum4;

  logic       iv8 = 1'b0, cin8 = 1'b0, or8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       ir8w, ov8w, ir8n, ov8n;
  logic [8:0] sum8w, sum8n;

`ifdef DIGIT_SERIAL_ADDER_SUBTRACT_EN
  logic sub4 = 1'b0;
  logic sub8 = 1'b0;
`endif

  int passed = 0;
  int total  = 0;

  logic [4:0] q4[$];
  logic [8:0] q8w[$];
  logic [8:0] q8n[$];

  digit_serial_adder #(.N(4), .D(2)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .A(a4), .B(b4), .cin(cin4),
`ifdef DIGIT_SERIAL_ADDER_SUBTRACT_EN
    .sub(sub4),
`endif
    .out_valid(ov4), .out_ready(or4), .Sum(sum4)
  );

  digit_serial_adder #(.N(8), .D(8)) u_dut8w (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8w), .A(a8), .B(b8), .cin(cin8),
`ifdef DIGIT_SERIAL_ADDER_SUBTRACT_EN
    .sub(sub8),
`endif
    .out_valid(ov8w), .out_ready(or8), .Sum(sum8w)
  );

  digit_serial_adder #(.N(8), .D(1)) u_dut8n (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8n), .A(a8), .B(b8), .cin(cin8),
`ifdef DIGIT_SERIAL_ADDER_SUBTRACT_EN
    .sub(sub8),
`endif
    .out_valid(ov8n), .out_ready(or8), .Sum(sum8n)
  );

  function automatic logic [4:0] model4(input logic [3:0] a, input logic [3:0] b,
                                        input logic c, input logic s);
    if (s) return {1'b0, a} + {1'b0, ~b} + 5'd1;
    return {1'b0, a} + {1'b0, b} + {4'd0, c};
  endfunction

  // Present operands until accepted; pushes the expected sum on acceptance.
  task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic c,
                       input logic [4:0] exp, output logic ok);
    int n = 0;
    a4 = a; b4 = b; cin4 = c; iv4 = 1'b1;
    while (ir4 !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    ok = (ir4 === 1'b1);
    if (!ok) begin
      iv4 = 1'b0;
      return;
    end
    q4.push_back(exp);
    @(negedge clk);
    iv4 = 1'b0;
  endtask

  // Wait (bounded) for out_valid; returns the sum and cycles waited.
  task automatic recv4(output logic ok, output logic [4:0] s, output int lat);
    int n = 0;
    while (ov4 !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    ok  = (ov4 === 1'b1);
    s   = sum4;
    lat = n;
  endtask

  task automatic test_reset;
    @(negedge clk);
    total++; if (ir4 !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", ir4); else passed++;
    total++; if (ov4 !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", ov4); else passed++;
    total++; if (sum4 !== 5'd0) $display("FAIL reset_sum: got %b want 00000", sum4); else passed++;
    total++; if ({ov8w, ov8n, sum8w, sum8n} !== 20'd0) $display("FAIL reset_wide: got %h want 0", {ov8w, ov8n, sum8w, sum8n}); else passed++;
    rst = 1'b0;
    @(negedge clk);
    total++; if (ir4 !== 1'b1) $display("FAIL idle_in_ready: got %b want 1", ir4); else passed++;
  endtask

  task automatic test_basic;
    logic ok; logic [4:0] s, exp; int lat;
    or4 = 1'b1;
    send4(4'b0010, 4'b1111, 1'b0, 5'b10001, ok);
    total++; if (!ok) $display("FAIL basic_accept: got timeout want accept"); else passed++;
    total++; if (ir4 !== 1'b0) $display("FAIL basic_busy_ready: got %b want 0", ir4); else passed++;
    recv4(ok, s, lat);
    total++; if (!ok) $display("FAIL basic_out_valid: got timeout want valid"); else passed++;
    total++; if (lat !== 2) $display("FAIL basic_latency: got %0d want 2", lat); else passed++;
    exp = (q4.size() > 0) ? q4.pop_front() : 5'bxxxxx;
    total++; if (s !== exp) $display("FAIL basic_sum: got %b want %b", s, exp); else passed++;
    @(negedge clk);
    total++; if (ov4 !== 1'b0) $display("FAIL basic_valid_clear: got %b want 0", ov4); else passed++;
    total++; if (ir4 !== 1'b1) $display("FAIL basic_ready_return: got %b want 1", ir4); else passed++;
  endtask

  task automatic test_back_to_back;
    logic ok; logic [4:0] s, exp; int lat; logic seen;
    or4 = 1'b1;
    send4(4'b1101, 4'b1101, 1'b0, 5'b11010, ok);
    total++; if (!ok) $display("FAIL b2b_accept1: got timeout want accept"); else passed++;
    // Stray pulse while busy must be dropped.
    a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1; iv4 = 1'b1;
    total++; if (ir4 !== 1'b0) $display("FAIL b2b_run_ready: got %b want 0", ir4); else passed++;
    @(negedge clk);
    iv4 = 1'b0;
    recv4(ok, s, lat);
    exp = (q4.size() > 0) ? q4.pop_front() : 5'bxxxxx;
    total++; if (!ok || s !== exp) $display("FAIL b2b_sum1: got %b (valid %b) want %b", s, ok, exp); else passed++;
    total++; if (ir4 !== 1'b0) $display("FAIL b2b_done_ready: got %b want 0", ir4); else passed++;
    send4(4'b1111, 4'b0000, 1'b1, 5'b10000, ok);
    total++; if (!ok) $display("FAIL b2b_accept2: got timeout want accept"); else passed++;
    recv4(ok, s, lat);
    exp = (q4.size() > 0) ? q4.pop_front() : 5'bxxxxx;
    total++; if (!ok || s !== exp) $display("FAIL b2b_sum2: got %b (valid %b) want %b", s, ok, exp); else passed++;
    @(negedge clk);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (ov4 === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    total++; if (seen !== 1'b0) $display("FAIL b2b_no_extra: got extra out_valid want none"); else passed++;
  endtask

  task automatic test_backpressure;
    logic ok; logic [4:0] s, exp; int lat;
    or4 = 1'b0;
    send4(4'b1100, 4'b1001, 1'b0, 5'b10101, ok);
    total++; if (!ok) $display("FAIL bp_accept: got timeout want accept"); else passed++;
    recv4(ok, s, lat);
    exp = (q4.size() > 0) ? q4.pop_front() : 5'bxxxxx;
    total++; if (!ok) $display("FAIL bp_out_valid: got timeout want valid"); else passed++;
    for (int i = 0; i < 5; i++) begin
      total++; if (ov4 !== 1'b1) $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, ov4); else passed++;
      total++; if (sum4 !== exp) $display("FAIL bp_hold_sum[%0d]: got %b want %b", i, sum4, exp); else passed++;
      @(negedge clk);
    end
    or4 = 1'b1;
    @(negedge clk);
    total++; if (ov4 !== 1'b0) $display("FAIL bp_release: got %b want 0", ov4); else passed++;
  endtask

  task automatic test_reset_mid_run;
    logic ok; logic [4:0] s, exp; int lat; logic seen;
    or4 = 1'b1;
    send4(4'b0101, 4'b1110, 1'b0, 5'b10011, ok);
    total++; if (!ok) $display("FAIL rst_accept: got timeout want accept"); else passed++;
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (ov4 !== 1'b0) $display("FAIL rst_mid_valid: got %b want 0", ov4); else passed++;
    total++; if (sum4 !== 5'd0) $display("FAIL rst_mid_sum: got %b want 00000", sum4); else passed++;
    total++; if (ir4 !== 1'b0) $display("FAIL rst_mid_ready: got %b want 0", ir4); else passed++;
    q4.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (ir4 !== 1'b1) $display("FAIL rst_idle: got in_ready %b want 1", ir4); else passed++;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ov4 === 1'b1) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) $display("FAIL rst_discard: got out_valid want none"); else passed++;
    send4(4'b0001, 4'b0001, 1'b0, 5'b00010, ok);
    recv4(ok, s, lat);
    exp = (q4.size() > 0) ? q4.pop_front() : 5'bxxxxx;
    total++; if (!ok || s !== exp) $display("FAIL rst_next_sum: got %b (valid %b) want %b", s, ok, exp); else passed++;
    @(negedge clk);
  endtask

  task automatic test_wide;
    int lat_w = 0, lat_n = 0;
    logic [8:0] got_w = '0, got_n = '0, exp;
    or8 = 1'b1;
    a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; iv8 = 1'b1;
    total++; if ({ir8w, ir8n} !== 2'b11) $display("FAIL wide_ready: got %b want 11", {ir8w, ir8n}); else passed++;
    q8w.push_back(9'h100);
    q8n.push_back(9'h100);
    @(negedge clk);
    iv8 = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (ov8w === 1'b1 && lat_w == 0) begin lat_w = n; got_w = sum8w; end
      if (ov8n === 1'b1 && lat_n == 0) begin lat_n = n; got_n = sum8n; end
    end
    total++; if (lat_w !== 1) $display("FAIL wide_d8_latency: got %0d want 1", lat_w); else passed++;
    total++; if (lat_n !== 8) $display("FAIL wide_d1_latency: got %0d want 8", lat_n); else passed++;
    exp = (q8w.size() > 0) ? q8w.pop_front() : 9'hxxx;
    total++; if (got_w !== exp) $display("FAIL wide_d8_sum: got %h want %h", got_w, exp); else passed++;
    exp = (q8n.size() > 0) ? q8n.pop_front() : 9'hxxx;
    total++; if (got_n !== exp) $display("FAIL wide_d1_sum: got %h want %h", got_n, exp); else passed++;
  endtask

  task automatic test_random;
    logic ok; logic [4:0] s, exp; int lat;
    logic [3:0] a, b; logic c, sb;
    for (int i = 0; i < 16; i++) begin
      a  = 4'($urandom_range(0, 15));
      b  = 4'($urandom_range(0, 15));
      c  = 1'($urandom_range(0, 1));
      sb = 1'b0;
`ifdef DIGIT_SERIAL_ADDER_SUBTRACT_EN
      sb = 1'($urandom_range(0, 1));
      sub4 = sb;
`endif
      or4 = 1'b0;
      send4(a, b, c, model4(a, b, c, sb), ok);
      recv4(ok, s, lat);
      for (int k = $urandom_range(0, 3); k > 0; k--) @(negedge clk);
      exp = (q4.size() > 0) ? q4.pop_front() : 5'bxxxxx;
      total++; if (!ok || sum4 !== exp) $display("FAIL rand_sum[%0d]: a=%h b=%h c=%b sub=%b got %b want %b", i, a, b, c, sb, sum4, exp); else passed++;
      or4 = 1'b1;
      @(negedge clk);
    end
`ifdef DIGIT_SERIAL_ADDER_SUBTRACT_EN
    sub4 = 1'b0;
`endif
  endtask

`ifdef DIGIT_SERIAL_ADDER_SUBTRACT_EN
  task automatic test_subtract;
    logic ok; logic [4:0] s, exp; int lat;
    or4 = 1'b1;
    sub4 = 1'b1;
    send4(4'b0101, 4'b1110, 1'b0, 5'b00111, ok);
    recv4(ok, s, lat);
    exp = (q4.size() > 0) ? q4.pop_front() : 5'bxxxxx;
    total++; if (!ok || s !== exp) $display("FAIL sub_borrow: got %b (valid %b) want %b", s, ok, exp); else passed++;
    send4(4'b1110, 4'b0101, 1'b1, 5'b11001, ok);
    recv4(ok, s, lat);
    exp = (q4.size() > 0) ? q4.pop_front() : 5'bxxxxx;
    total++; if (!ok || s !== exp) $display("FAIL sub_no_borrow: got %b (valid %b) want %b", s, ok, exp); else passed++;
    sub4 = 1'b0;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_run();
    test_wide();
`ifdef DIGIT_SERIAL_ADDER_SUBTRACT_EN
    test_subtract();
`endif
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
